// File: rtl/demux32_wr_buf.sv
// Write port for a 32-entry register bank: valid/ready request intake, 2-deep FIFO, one-hot commit.
// Optional DEMUX32_ZERO_REG_EN: entry 0 is hardwired to zero and never shows as pending.
module demux32_wr_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [4:0]                  wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        commit_stall,
  output logic [31:0][WIDTH-1:0]      entries,
  output logic [31:0]                 pending,
  output logic                        busy
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned NENTRY  = 32;
`ifdef DEMUX32_ZERO_REG_EN
  localparam int unsigned FIRST_WR = 1;
`else
  localparam int unsigned FIRST_WR = 0;
`endif

  logic [CNT_W-1:0] count;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [4:0]       slot_addr [DEPTH];
  logic [WIDTH-1:0] slot_data [DEPTH];

  logic             push;
  logic             pop;
  logic [4:0]       head_addr;
  logic [WIDTH-1:0] head_data;
  logic [31:0]      wr_sel;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign wr_ready  = !rst && (count != CNT_W'(DEPTH));
  assign push      = wr_valid && wr_ready;
  assign pop       = (count != '0) && !commit_stall;
  assign head_addr = slot_addr[rd_ptr];
  assign head_data = slot_data[rd_ptr];
  assign busy      = (count != '0);

  // 5-to-32 one-hot write enable for the FIFO head.
  always_comb begin
    wr_sel = '0;
    if (pop) wr_sel = 32'(1) << head_addr;
  end

  // Entries targeted by any buffered, not yet committed write.
  always_comb begin
    pending = '0;
    if (count != '0) pending = pending | (32'(1) << slot_addr[rd_ptr]);
    if (count == CNT_W'(DEPTH)) pending = pending | (32'(1) << slot_addr[~rd_ptr]);
`ifdef DEMUX32_ZERO_REG_EN
    pending[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO payload needs no reset; slot contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      slot_addr[wr_ptr] <= wr_addr;
      slot_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries <= '0;
    end else begin
      for (int unsigned j = FIRST_WR; j < NENTRY; j++) begin
        if (wr_sel[j]) entries[j] <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_demux32_wr_buf.sv
// Directed, table-driven bench for demux32_wr_buf; honours DEMUX32_ZERO_REG_EN for entry-0 expectations.
module tb_demux32_wr_buf;

  localparam int unsigned WIDTH = 32;
`ifdef DEMUX32_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [4:0]             wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   commit_stall;
  logic [31:0][WIDTH-1:0] entries;
  logic [31:0]            pending;
  logic                   busy;

  int n_chk  = 0;
  int n_fail = 0;

  demux32_wr_buf #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit_stall(commit_stall),
    .entries(entries), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic        ready;
    logic        bsy;
    logic [31:0] pend;
    logic [4:0]  idx;
    logic [31:0] val;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    for (int j = 0; j < 32; j++) chk($sformatf("%s entry%0d", name, j), 64'(entries[j]), 64'd0);
    chk({name, " pending"}, 64'(pending), 64'd0);
    chk({name, " busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    // Each record: inputs driven for one edge, then state expected after that edge.
    //            valid addr   data          stall ready busy pending             idx    val
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'h0000_0020,    5'd5,  32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0,            5'd5,  32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd3,  32'h11,       1'b1, 1'b1, 1'b1, 32'h0000_0008,    5'd3,  32'h0};
    vecs[3]  = '{1'b1, 5'd7,  32'h22,       1'b1, 1'b0, 1'b1, 32'h0000_0088,    5'd7,  32'h0};
    vecs[4]  = '{1'b1, 5'd9,  32'h99,       1'b1, 1'b0, 1'b1, 32'h0000_0088,    5'd9,  32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0080,    5'd3,  32'h11};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0,            5'd7,  32'h22};
    vecs[7]  = '{1'b1, 5'd9,  32'hA,        1'b0, 1'b1, 1'b1, 32'h0000_0200,    5'd9,  32'h0};
    vecs[8]  = '{1'b1, 5'd9,  32'hB,        1'b0, 1'b1, 1'b1, 32'h0000_0200,    5'd9,  32'hA};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0,            5'd9,  32'hB};
    vecs[10] = '{1'b0, 5'd9,  32'h55,       1'b1, 1'b1, 1'b0, 32'h0,            5'd9,  32'hB};
    vecs[11] = '{1'b1, 5'd1,  32'h1,        1'b1, 1'b1, 1'b1, 32'h0000_0002,    5'd1,  32'h0};
    vecs[12] = '{1'b1, 5'd2,  32'h2,        1'b1, 1'b0, 1'b1, 32'h0000_0006,    5'd2,  32'h0};
    vecs[13] = '{1'b1, 5'd4,  32'h4,        1'b0, 1'b1, 1'b1, 32'h0000_0004,    5'd1,  32'h1};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0,            5'd2,  32'h2};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0,            5'd4,  32'h0};
    vecs[16] = '{1'b1, 5'd0,  32'hFF,       1'b0, 1'b1, 1'b1, (ZR ? 32'h0 : 32'h1), 5'd0, 32'h0};
    vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0,            5'd0,  (ZR ? 32'h0 : 32'hFF)};

    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit_stall = 1'b0;
    step();
    chk("ready_in_reset", 64'(wr_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 64'(wr_ready), 64'd1);
    chk_all_zero("reset");
    step();
    chk("idle_ready", 64'(wr_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < NV; i++) begin
      wr_valid = vecs[i].valid; wr_addr = vecs[i].addr;
      wr_data = vecs[i].data;   commit_stall = vecs[i].stall;
      step();
      chk($sformatf("v%0d ready", i),   64'(wr_ready), 64'(vecs[i].ready));
      chk($sformatf("v%0d busy", i),    64'(busy),     64'(vecs[i].bsy));
      chk($sformatf("v%0d pending", i), 64'(pending),  64'(vecs[i].pend));
      chk($sformatf("v%0d entry%0d", i, vecs[i].idx), 64'(entries[vecs[i].idx]), 64'(vecs[i].val));
    end
    chk("entry0_zero_reg", 64'(entries[0]), (ZR ? 64'd0 : 64'hFF));

    // Back-to-back stream to every index: ready holds, busy drops one edge after the last accept.
    commit_stall = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'(i + 1);
      step();
      chk($sformatf("b2b ready %0d", i), 64'(wr_ready), 64'd1);
      chk($sformatf("b2b busy %0d", i),  64'(busy),     64'd1);
    end
    wr_valid = 1'b0;
    step();
    chk("b2b busy_fall", 64'(busy), 64'd0);
    for (int j = 0; j < 32; j++)
      chk($sformatf("b2b entry%0d", j), 64'(entries[j]), (ZR && j == 0) ? 64'd0 : 64'(j + 1));

    // Reset while two writes are stalled in the FIFO: nothing may commit afterwards.
    commit_stall = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 32'hAAAA;
    step();
    wr_addr = 5'd11; wr_data = 32'hBBBB;
    step();
    chk("rst_mid full", 64'(wr_ready), 64'd0);
    chk("rst_mid pending", 64'(pending), 64'h0C00);
    wr_valid = 1'b0; commit_stall = 1'b0; rst = 1'b1;
    #1;
    chk("rst_mid ready_low", 64'(wr_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    step();
    step();
    chk_all_zero("post_rst");
    chk("post_rst ready", 64'(wr_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
